// File: rtl/serial_tx_bridge_if.sv
// Byte-stream bundle between a strobe-only source, the bridge and a ready/strobe sink.
// Handshake: in_strobe is a one-cycle "take in_data now" pulse with no back-pressure;
// the sink raises out_ready when it can take a byte, and out_strobe is a one-cycle
// pulse on which the sink latches out_data.
interface serial_tx_bridge_if;
   logic [7:0] in_data;
   logic       in_strobe;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_strobe;

   modport master (
      output in_data, in_strobe, out_ready,
      input  out_data, out_strobe
   );

   modport slave (
      input  in_data, in_strobe, out_ready,
      output out_data, out_strobe
   );
endinterface

// File: rtl/serial_tx_bridge.sv
// Buffered byte bridge: FIFO absorbs source bursts, FSM drains one byte per sink-ready
// window and ignores out_ready for HOLDOFF cycles after each strobe.
module serial_tx_bridge #(
   parameter int DEPTH   = 16,
   parameter int HOLDOFF = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   serial_tx_bridge_if.slave        bus,
   input  logic                     clear,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic [7:0]               drop_count,
   output logic                     state_dbg
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t        state_q;
   logic [3:0]    timer_q;
   logic [7:0]    out_data_q;
   logic          out_strobe_q;
   logic [PW-1:0] wr_q, wr_d;
   logic [PW-1:0] rd_q, rd_d;
   logic          overflow_q, overflow_d;
   logic [7:0]    drop_q, drop_d;
   logic [7:0]    mem_q [DEPTH];

   logic [PW-1:0] level_c;
   logic          full_c, empty_c;
   logic          do_wr, do_drop, do_rd;

   // Full/empty come from pre-cycle pointers, so a same-cycle read never frees room for a write.
   always_comb begin
      level_c = wr_q - rd_q;
      full_c  = (level_c == PW'(DEPTH));
      empty_c = (level_c == '0);
      do_wr   = bus.in_strobe && !full_c && !clear;
      do_drop = bus.in_strobe &&  full_c && !clear;
      do_rd   = (state_q == IDLE) && !empty_c && bus.out_ready && !clear;
   end

   always_comb begin
      wr_d       = wr_q;
      rd_d       = rd_q;
      overflow_d = overflow_q;
      drop_d     = drop_q;
      if (clear) begin
         wr_d       = '0;
         rd_d       = '0;
         overflow_d = 1'b0;
         drop_d     = '0;
      end else begin
         if (do_wr) wr_d = wr_q + PW'(1);
         if (do_rd) rd_d = rd_q + PW'(1);
         if (do_drop) begin
            overflow_d = 1'b1;
            if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_q[AW-1:0]] <= bus.in_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_q       <= '0;
         rd_q       <= '0;
         overflow_q <= 1'b0;
         drop_q     <= '0;
      end else begin
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         overflow_q <= overflow_d;
         drop_q     <= drop_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         timer_q      <= '0;
         out_data_q   <= '0;
         out_strobe_q <= 1'b0;
      end else if (clear) begin
         state_q      <= IDLE;
         timer_q      <= '0;
         out_strobe_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               out_strobe_q <= 1'b0;
               if (do_rd) begin
                  out_data_q   <= mem_q[rd_q[AW-1:0]];
                  out_strobe_q <= 1'b1;
                  timer_q      <= 4'(HOLDOFF - 1);
                  state_q      <= HOLD;
               end
            end
            HOLD: begin
               // out_ready may still reflect the previous byte here; never look at it.
               out_strobe_q <= 1'b0;
               if (timer_q == '0) state_q <= IDLE;
               else               timer_q <= timer_q - 4'd1;
            end
            default: begin
               out_strobe_q <= 1'b0;
               state_q      <= IDLE;
            end
         endcase
      end
   end

   assign bus.out_data   = out_data_q;
   assign bus.out_strobe = out_strobe_q;
   assign level          = level_c;
   assign overflow       = overflow_q;
   assign drop_count     = drop_q;
   assign state_dbg      = state_q;
endmodule
